barrel_scheduler: RTL and testbench

- Sequences barrel launches for the playfield, keyed to Kong's throw animation.
- Watches Kong's 2-bit animation state and a pool of NUM_BARRELS barrel-object slots.
- On each GET→HOLD→DROP throw cycle, grants one free slot, round-robin, with a one-cycle spawn pulse plus a fixed spawn position.
- Sits between the Kong sprite controller and the barrel instances; also reports launch and miss statistics to the score/HUD logic.

---
 rtl/barrel_pkg.sv | 34 +++
 rtl/rr_free_select.sv | 35 +++
 rtl/barrel_scheduler.sv | 123 ++++++++++++
 tb/tb_barrel_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared encodings and defaults for the barrel scheduler
package barrel_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WAIT_GET  = 2'b01,
    S_WAIT_DROP = 2'b10,
    S_COOLDOWN  = 2'b11
  } sched_state_t;

  // Kong animation states, shared with the Kong controller and sprite renderer
  typedef enum logic [1:0] {
    ANIM_NORMAL = 2'b00,
    ANIM_GET    = 2'b01,
    ANIM_HOLD   = 2'b10,
    ANIM_DROP   = 2'b11
  } kong_anim_t;

  localparam int DEF_NUM_BARRELS = 4;
  localparam int DEF_SPAWN_X     = 160;
  localparam int DEF_SPAWN_Y     = 100;
  localparam int DEF_COOLDOWN    = 32;

  // Saturating increment for the HUD statistics counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rr_free_select.sv
// rtl/rr_free_select.sv - round-robin search for the first free barrel slot
module rr_free_select #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  busy_i,
  input  logic [PW-1:0] ptr_i,
  output logic          hit_o,
  output logic [PW-1:0] idx_o,
  output logic [N-1:0]  grant_o
);

  int            j;
  logic [PW-1:0] jsel;

  // Scan from the farthest offset back to the pointer so the nearest free slot wins
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    j     = 0;
    jsel  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jsel = PW'(j);
      if (!busy_i[jsel]) begin
        hit_o = 1'b1;
        idx_o = jsel;
      end
    end
  end

  assign grant_o = hit_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/barrel_scheduler.sv
// rtl/barrel_scheduler.sv - launches one barrel per Kong throw cycle, round-robin over slots
module barrel_scheduler
  import barrel_pkg::*;
#(
  parameter int NUM_BARRELS = DEF_NUM_BARRELS,
  parameter int SPAWN_X     = DEF_SPAWN_X,
  parameter int SPAWN_Y     = DEF_SPAWN_Y,
  parameter int COOLDOWN    = DEF_COOLDOWN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   over,
  input  logic [1:0]             kong_anim,
  input  logic [NUM_BARRELS-1:0] barrel_busy,
  output logic [NUM_BARRELS-1:0] spawn,
  output logic [9:0]             spawn_x,
  output logic [8:0]             spawn_y,
  output logic [1:0]             state,
  output logic [7:0]             launch_count,
  output logic [3:0]             miss_count
);

  localparam int PW = $clog2(NUM_BARRELS);
  localparam int CW = $clog2(COOLDOWN);

  sched_state_t           state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_BARRELS-1:0] spawn_q, spawn_d;
  logic [7:0]             launch_q, launch_d;
  logic [3:0]             miss_q, miss_d;

  logic                   sel_hit;
  logic [PW-1:0]          sel_idx;
  logic [NUM_BARRELS-1:0] sel_grant;

  rr_free_select #(
    .N  (NUM_BARRELS),
    .PW (PW)
  ) u_sel (
    .busy_i  (barrel_busy),
    .ptr_i   (ptr_q),
    .hit_o   (sel_hit),
    .idx_o   (sel_idx),
    .grant_o (sel_grant)
  );

  // Next-state: throw sequencing, slot grant on DROP, over aborts to idle
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    spawn_d  = '0;
    launch_d = launch_q;
    miss_d   = miss_q;

    if (state_q == S_IDLE) begin
      if (start && !over) begin
        state_d  = S_WAIT_GET;
        launch_d = '0;
        miss_d   = '0;
        ptr_d    = '0;
      end
    end else if (over) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT_GET: begin
          if (kong_anim == ANIM_GET) state_d = S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          if (kong_anim == ANIM_DROP) begin
            state_d = S_COOLDOWN;
            cnt_d   = CW'(COOLDOWN - 1);
            if (sel_hit) begin
              spawn_d  = sel_grant;
              ptr_d    = (sel_idx == PW'(NUM_BARRELS - 1)) ? '0 : sel_idx + PW'(1);
              launch_d = sat_inc8(launch_q);
            end else begin
              miss_d   = sat_inc4(miss_q);
            end
          end
        end
        S_COOLDOWN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (kong_anim == ANIM_NORMAL) begin
            state_d = S_WAIT_GET;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and statistics registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      spawn_q  <= '0;
      launch_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      spawn_q  <= spawn_d;
      launch_q <= launch_d;
      miss_q   <= miss_d;
    end
  end

  assign spawn        = spawn_q;
  assign spawn_x      = 10'(SPAWN_X);
  assign spawn_y      = 9'(SPAWN_Y);
  assign state        = state_q;
  assign launch_count = launch_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_barrel_scheduler.sv
// tb/tb_barrel_scheduler.sv - scoreboard bench for barrel_scheduler
module tb_barrel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       over;
  logic [1:0] kong_anim;
  logic [3:0] barrel_busy;
  logic [3:0] spawn;
  logic [9:0] spawn_x;
  logic [8:0] spawn_y;
  logic [1:0] state;
  logic [7:0] launch_count;
  logic [3:0] miss_count;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  barrel_scheduler #(
    .NUM_BARRELS (4),
    .SPAWN_X     (160),
    .SPAWN_Y     (100),
    .COOLDOWN    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .over         (over),
    .kong_anim    (kong_anim),
    .barrel_busy  (barrel_busy),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .state        (state),
    .launch_count (launch_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  // Monitor: every visible spawn pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && spawn != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spawn_unexpected actual=%b required=none", spawn);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (spawn !== e) begin
          failures++;
          $display("FAIL spawn_grant actual=%b required=%b", spawn, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One GET/HOLD/DROP throw; exp is the grant expected (0 for a miss). Leaves FSM back in WAIT_GET.
  task automatic throw_cycle(input logic [3:0] exp);
    kong_anim = 2'b01; step();
    kong_anim = 2'b10; step();
    if (exp != 4'b0000) exp_q.push_back(exp);
    kong_anim = 2'b11; step();
    kong_anim = 2'b00;
    for (int i = 0; i < 32; i++) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; over = 1'b0; kong_anim = 2'b00; barrel_busy = 4'b0000;
    #12;
    chk("reset_state", state, 2'b00);
    chk("reset_spawn", spawn, 4'b0000);
    chk("reset_launch", launch_count, 8'd0);
    chk("reset_miss", miss_count, 4'd0);
    chk("spawn_x", spawn_x, 10'd160);
    chk("spawn_y", spawn_y, 9'd100);
    rst = 1'b0;
    step();

    start = 1'b1; step(); start = 1'b0;
    chk("start_state", state, 2'b01);

    // First throw, step by step
    kong_anim = 2'b01; step();
    chk("get_state", state, 2'b10);
    kong_anim = 2'b10; step();
    chk("hold_state", state, 2'b10);
    exp_q.push_back(4'b0001);
    kong_anim = 2'b11; step();
    chk("drop_state", state, 2'b11);
    chk("first_launch", launch_count, 8'd1);
    kong_anim = 2'b00;
    for (int i = 0; i < 31; i++) step();
    chk("cooldown_edge_state", state, 2'b11);
    step();
    chk("cooldown_exit_state", state, 2'b01);

    throw_cycle(4'b0010);
    throw_cycle(4'b0100);
    throw_cycle(4'b1000);
    chk("four_launch", launch_count, 8'd4);
    throw_cycle(4'b0001);

    // Pointer now 1; busy slot 0 grants slot 1 and moves pointer to 2
    barrel_busy = 4'b0001; throw_cycle(4'b0010);
    barrel_busy = 4'b0100; throw_cycle(4'b1000);
    barrel_busy = 4'b0000; throw_cycle(4'b0001);
    chk("ptr_launch", launch_count, 8'd8);

    // All busy: miss
    barrel_busy = 4'b1111;
    kong_anim = 2'b01; step();
    kong_anim = 2'b10; step();
    kong_anim = 2'b11; step();
    chk("miss_state", state, 2'b11);
    chk("miss_count", miss_count, 4'd1);
    chk("miss_launch", launch_count, 8'd8);
    kong_anim = 2'b00;
    for (int i = 0; i < 32; i++) step();
    barrel_busy = 4'b0000;

    // DROP held for 100 cycles fires once
    kong_anim = 2'b01; step();
    kong_anim = 2'b10; step();
    exp_q.push_back(4'b0010);
    kong_anim = 2'b11;
    for (int i = 0; i < 100; i++) step();
    chk("held_drop_state", state, 2'b11);
    chk("held_drop_launch", launch_count, 8'd9);
    kong_anim = 2'b00; step();
    chk("held_drop_release", state, 2'b01);

    // over coincident with DROP
    kong_anim = 2'b01; step();
    kong_anim = 2'b10; step();
    kong_anim = 2'b11; over = 1'b1; step();
    chk("over_state", state, 2'b00);
    chk("over_spawn", spawn, 4'b0000);
    chk("over_launch_hold", launch_count, 8'd9);
    chk("over_miss_hold", miss_count, 4'd1);
    kong_anim = 2'b00; over = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_launch", launch_count, 8'd0);
    chk("restart_miss", miss_count, 4'd0);

    // Async reset while the spawn pulse is in flight
    kong_anim = 2'b01; step();
    kong_anim = 2'b10; step();
    kong_anim = 2'b11; step();
    chk("inflight_spawn", spawn, 4'b0001);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_spawn", spawn, 4'b0000);
    chk("async_rst_state", state, 2'b00);
    chk("async_rst_launch", launch_count, 8'd0);
    kong_anim = 2'b00;
    step();
    rst = 1'b0;
    step();

    // Saturation of both counters
    start = 1'b1; step(); start = 1'b0;
    barrel_busy = 4'b1111;
    for (int i = 0; i < 17; i++) throw_cycle(4'b0000);
    chk("miss_saturate", miss_count, 4'd15);
    barrel_busy = 4'b0000;
    for (int i = 0; i < 257; i++) begin
      logic [3:0] g;
      g = 4'b0001 << (i % 4);
      throw_cycle(g);
    end
    chk("launch_saturate", launch_count, 8'd255);

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
